// File: rtl/par2ser_msb.sv
// Parallel-to-serial feeder: valid/ready word intake, MSB-first serial out with sof/eof framing.
// Optional PAR2SER_PARITY_EN appends an even-parity bit to each frame and moves eof onto it.
module par2ser_msb #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              ser_dout,
  output logic              ser_valid,
  output logic              ser_sof,
  output logic              ser_eof,
  output logic              busy,
  output logic [15:0]       word_cnt
);

  localparam int unsigned        CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(DATA_W - 1);
  localparam logic [7:0]         GAP_INIT = 8'(GAP_CYCLES);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t            state, state_d;
  logic [DATA_W-1:0] sreg;
  logic [CNT_W-1:0]  bit_cnt;
  logic [7:0]        gap_cnt;
  logic              rdy_en;
  logic              last;
  logic              accept;
`ifdef PAR2SER_PARITY_EN
  logic              par_bit;
  logic              par_phase;
`endif

  // rdy_en keeps in_ready low during reset even though state already reads IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      rdy_en <= 1'b0;
    end else begin
      state  <= state_d;
      rdy_en <= 1'b1;
    end
  end

  always_comb begin
    state_d = state;
`ifdef PAR2SER_PARITY_EN
    last = (state == SHIFT) && par_phase;
`else
    last = (state == SHIFT) && (bit_cnt == '0);
`endif
    in_ready = rdy_en && ((state == IDLE) || (last && (GAP_CYCLES == 0)));
    accept   = in_valid && in_ready;
    busy     = (state != IDLE);
    case (state)
      IDLE:  if (accept) state_d = SHIFT;
      SHIFT: begin
        if (last) begin
          if (accept)              state_d = SHIFT;
          else if (GAP_CYCLES > 0) state_d = GAP;
          else                     state_d = IDLE;
        end
      end
      GAP:     if (gap_cnt <= 8'd1) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg      <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      ser_dout  <= 1'b0;
      ser_valid <= 1'b0;
      ser_sof   <= 1'b0;
      ser_eof   <= 1'b0;
      word_cnt  <= '0;
`ifdef PAR2SER_PARITY_EN
      par_bit   <= 1'b0;
      par_phase <= 1'b0;
`endif
    end else begin
      if (last) word_cnt <= word_cnt + 16'd1;

      if (last && !accept)    gap_cnt <= GAP_INIT;
      else if (state == GAP)  gap_cnt <= gap_cnt - 8'd1;

      if (accept) begin
        sreg      <= in_data;
        bit_cnt   <= CNT_LOAD;
        ser_dout  <= in_data[DATA_W-1];
        ser_valid <= 1'b1;
        ser_sof   <= 1'b1;
        ser_eof   <= 1'b0;
`ifdef PAR2SER_PARITY_EN
        par_bit   <= ^in_data;
        par_phase <= 1'b0;
`endif
      end else if ((state == SHIFT) && !last) begin
        ser_sof <= 1'b0;
`ifdef PAR2SER_PARITY_EN
        if (bit_cnt == '0) begin
          ser_dout  <= par_bit;
          ser_eof   <= 1'b1;
          par_phase <= 1'b1;
        end else begin
          sreg     <= sreg << 1;
          ser_dout <= sreg[DATA_W-2];
          bit_cnt  <= bit_cnt - 1'b1;
          ser_eof  <= 1'b0;
        end
`else
        sreg     <= sreg << 1;
        ser_dout <= sreg[DATA_W-2];
        bit_cnt  <= bit_cnt - 1'b1;
        ser_eof  <= (bit_cnt == CNT_W'(1));
`endif
      end else begin
        ser_dout  <= 1'b0;
        ser_valid <= 1'b0;
        ser_sof   <= 1'b0;
        ser_eof   <= 1'b0;
      end
    end
  end

endmodule
